vec_store_buffer: RTL and testbench

Store buffer between the single-cycle ARM core's data-side outputs and the data memory. It captures scalar stores (one word) and vector stores (five words from VecWriteData_0..4) in one core cycle. It then drains them to a single-port, one-word-per-cycle memory interface with a valid/ready handshake. It stalls the core when the buffer is full, and stalls loads until all pending stores have drained, which preserves memory ordering.

---
 rtl/vec_store_buffer.sv | 99 +++++++++
 tb/tb_vec_store_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/vec_store_buffer.sv
// Store buffer between core data port and single-port data memory.
// Holds scalar/vector stores, drains one word per handshake in order.
module vec_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        VecStore,
  input  logic        MemRead,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] VecWriteData_0,
  input  logic [31:0] VecWriteData_1,
  input  logic [31:0] VecWriteData_2,
  input  logic [31:0] VecWriteData_3,
  input  logic [31:0] VecWriteData_4,
  output logic        stall,
  output logic        busy,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready
);

  typedef struct packed {
    logic [29:0]      addr;
    logic             vec;
    logic [4:0][31:0] data;
  } entry_t;

  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

  entry_t           buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [2:0]       widx;

  entry_t head;
  logic   full;
  logic   enq;
  logic   deq;
  logic   last;
  logic   pop;
  logic   unused;

  // Byte offset is dropped: all traffic is word-aligned.
  assign unused = ^ALUResult[1:0];

  assign head = buf_q[rd_ptr];
  assign full = (count == CNT_MAX);
  assign busy = (count != '0);
  assign stall = (MemWrite & full) |
                 (MemRead & ~MemWrite & busy);

  assign enq = MemWrite & ~full;
  assign mem_valid = busy;
  assign deq = mem_valid & mem_ready;
  assign last = head.vec ? (widx == 3'd4) : 1'b1;
  assign pop = deq & last;

  // Adding in the 30-bit word domain wraps past the top of memory.
  assign mem_addr = {head.addr + {27'b0, widx}, 2'b00};
  assign mem_wdata = head.data[widx];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      widx   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (deq) widx <= last ? 3'd0 : widx + 3'd1;
      unique case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_q[wr_ptr].addr    <= ALUResult[31:2];
      buf_q[wr_ptr].vec     <= VecStore;
      buf_q[wr_ptr].data[0] <= VecStore ? VecWriteData_0
                                        : WriteData;
      buf_q[wr_ptr].data[1] <= VecWriteData_1;
      buf_q[wr_ptr].data[2] <= VecWriteData_2;
      buf_q[wr_ptr].data[3] <= VecWriteData_3;
      buf_q[wr_ptr].data[4] <= VecWriteData_4;
    end
  end

endmodule

// File: tb/tb_vec_store_buffer.sv
// Bench for vec_store_buffer: per-cycle vector table for control
// outputs, scoreboard queue for every word written to memory.
module tb_vec_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        VecStore;
  logic        MemRead;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] VecWriteData_0;
  logic [31:0] VecWriteData_1;
  logic [31:0] VecWriteData_2;
  logic [31:0] VecWriteData_3;
  logic [31:0] VecWriteData_4;
  logic        stall;
  logic        busy;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    bit          mw;
    bit          vs;
    bit          mr;
    bit          rdy;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          es;
    bit          eb;
    bit          ev;
  } vec_t;

  wr_t  sb [$];
  vec_t tbl [$];

  vec_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemWrite       (MemWrite),
    .VecStore       (VecStore),
    .MemRead        (MemRead),
    .ALUResult      (ALUResult),
    .WriteData      (WriteData),
    .VecWriteData_0 (VecWriteData_0),
    .VecWriteData_1 (VecWriteData_1),
    .VecWriteData_2 (VecWriteData_2),
    .VecWriteData_3 (VecWriteData_3),
    .VecWriteData_4 (VecWriteData_4),
    .stall          (stall),
    .busy           (busy),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane(logic [31:0] wd, int i);
    return wd * 32'(i + 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(bit mw, bit vs, bit mr, bit rdy,
                       logic [31:0] addr, logic [31:0] wd);
    MemWrite  = mw;
    VecStore  = vs;
    MemRead   = mr;
    mem_ready = rdy;
    ALUResult = addr;
    WriteData = wd;
    VecWriteData_0 = vs ? lane(wd, 0) : ~wd;
    VecWriteData_1 = vs ? lane(wd, 1) : ~wd;
    VecWriteData_2 = vs ? lane(wd, 2) : ~wd;
    VecWriteData_3 = vs ? lane(wd, 3) : ~wd;
    VecWriteData_4 = vs ? lane(wd, 4) : ~wd;
  endtask

  // Called at the negedge: records what memory must see if accepted.
  task automatic push_if_taken(bit mw, bit vs,
                               logic [31:0] addr, logic [31:0] wd);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFFC;
    if (mw && !stall && !reset) begin
      if (vs) begin
        for (int i = 0; i < 5; i++)
          sb.push_back('{base + 32'(4 * i), lane(wd, i)});
      end else begin
        sb.push_back('{base, wd});
      end
    end
  endtask

  function automatic void add(bit mw, bit vs, bit mr, bit rdy,
                              logic [31:0] addr, logic [31:0] wd,
                              bit es, bit eb, bit ev);
    tbl.push_back('{mw, vs, mr, rdy, addr, wd, es, eb, ev});
  endfunction

  // Memory side: every accepted word must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write_unexpected: got %h@%h expected none",
                 mem_wdata, mem_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("mem_addr", mem_addr, e.a);
        chk("mem_wdata", mem_wdata, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1, 0, 1, 0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(mem_valid), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    add(1, 0, 0, 1, 32'h103, 32'hDEADBEEF, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 32'h200, 32'h11, 0, 0, 0);
    repeat (5) add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 32'h200, 32'h11, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      add(0, 0, 0, (k % 2) == 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      add(1, 0, 0, 0, 32'(32'h300 + 4 * k), 32'(32'hA0 + k),
          0, k != 0, k != 0);
    add(1, 0, 0, 0, 32'h310, 32'hA4, 1, 1, 1);
    add(1, 0, 0, 1, 32'h310, 32'hA4, 1, 1, 1);
    add(1, 0, 0, 1, 32'h310, 32'hA4, 0, 1, 1);
    repeat (3) add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 32'hFFFF_FFF8, 32'h21, 0, 0, 0);
    repeat (5) add(0, 0, 1, 1, 0, 0, 1, 1, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 32'h400, 32'h55AA, 0, 0, 0);
    add(1, 0, 1, 0, 32'h404, 32'h66, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.mw, v.vs, v.mr, v.rdy, v.addr, v.wd);
      @(negedge clk);
      chk($sformatf("stall[%0d]", i), 32'(stall), 32'(v.es));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'(v.eb));
      chk($sformatf("valid[%0d]", i), 32'(mem_valid), 32'(v.ev));
      push_if_taken(v.mw, v.vs, v.addr, v.wd);
      @(posedge clk); #1;
    end

    // Reset while the third word of a vector store is presented.
    drive(1, 1, 0, 1, 32'h500, 32'h31);
    @(negedge clk);
    push_if_taken(1, 1, 32'h500, 32'h31);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    drive(1, 0, 1, 1, 32'h600, 32'h77);
    @(negedge clk);
    chk("middrain_widx2_addr", mem_addr, 32'h508);
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(mem_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid[%0d]", c), 32'(mem_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
